raster_cmd_scheduler: RTL and testbench
=======================================

RASTER_CMD_SCHEDULER -- requirements
Module: raster_cmd_scheduler

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 64, number of processor pixel-output cycles per frame.
REQ-002 SHALL have parameter START_TIMEOUT, default 7, maximum WAIT_START cycles before abort.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port a_req, input, 1, requester A command request, held until a_ack.
REQ-007 SHALL have port a_cmd, input, 2, requester A command code.
REQ-008 SHALL have port a_args, input, 18, requester A arguments {x1,y1,x2,y2,rect_width,rect_height}, 3 bits each, x1 in MSBs.
REQ-009 SHALL have port a_ack, output, 1, one-cycle grant/consume pulse to A.
REQ-010 SHALL have ports b_req, b_cmd, b_args and b_ack, identical to the A ports, for requester B.
REQ-011 SHALL have port gp_command, output, 2, command to the graphics processor.
REQ-012 SHALL have port gp_args, output, 18, arguments to the graphics processor, same packing as a_args.
REQ-013 SHALL have port gp_command_valid, output, 1, one-cycle issue strobe.
REQ-014 SHALL have port gp_frame_start, input, 1, processor frame-start pulse.
REQ-015 SHALL have port frame_active, output, 1, high while processor pixels stream.
REQ-016 SHALL have port frame_owner, output, 1, 0 = A, 1 = B, owner of the current or last frame.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse at end of stream.
REQ-018 SHALL have port err_timeout, output, 1, one-cycle pulse on start timeout.
REQ-019 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT_START, STREAM, GUARD; all outputs registered.
REQ-021 IDLE: on any req sampled high, SHALL grant one requester, latch its cmd/args into gp_command/gp_args, record frame_owner, and go to ISSUE.
REQ-022 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; after reset, A wins a tie.
REQ-023 ISSUE (1 cycle) SHALL assert gp_command_valid and the granted requester's ack together, then go to WAIT_START with counter = 0.
REQ-024 Latency SHALL be: req sampled high at IDLE edge N -> ack and gp_command_valid high during cycle N+1 only.
REQ-025 gp_command/gp_args SHALL hold the latched values until the next grant.
REQ-026 WAIT_START: on gp_frame_start = 1, SHALL go to STREAM with counter = 0 and frame_active = 1.
REQ-027 WAIT_START: if START_TIMEOUT cycles elapse with no gp_frame_start, SHALL pulse err_timeout for 1 cycle and return to IDLE; the request is already consumed and SHALL NOT be reissued.
REQ-028 STREAM SHALL last exactly FRAME_PIXELS cycles (counter 0..FRAME_PIXELS-1), then pulse frame_done with frame_active falling in the same cycle, and go to GUARD.
REQ-029 GUARD SHALL last 1 cycle, the processor's return to IDLE, then go to IDLE.
REQ-030 Requests SHALL be ignored outside IDLE; a held req SHALL be served on the next IDLE cycle.
REQ-031 A req dropped before it is sampled in IDLE SHALL cause no issue and no ack.
REQ-032 gp_frame_start outside WAIT_START SHALL be ignored.
REQ-033 The counter SHALL be wide enough for max(FRAME_PIXELS, START_TIMEOUT) and SHALL never wrap within a state.

Reset
REQ-034 While rst = 1, asynchronously: state = IDLE; counter = 0; round-robin pointer = favour A; all outputs = 0 (gp_command, gp_args, gp_command_valid, a_ack, b_ack, frame_active, frame_owner, frame_done, err_timeout, busy).
REQ-035 Reset mid-frame SHALL abort with no frame_done or err_timeout pulse; the first post-reset req is handled as after power-up.

Verification
REQ-036 Single request: a_req = 1, a_cmd = 1, a_args = {3,5,0,0,0,0}; processor model returns frame_start 2 cycles after issue -> a_ack and gp_command_valid high in 1 cycle with gp_args = that value, frame_active high 64 cycles, one frame_done, busy low after GUARD.
REQ-037 Contention: a_req and b_req both held from reset -> grants in order A, B, A, B; frame_owner = 0, 1, 0, 1; each ack exactly once per frame.
REQ-038 Timeout: issue with gp_frame_start tied 0 -> err_timeout pulses 7 cycles after entering WAIT_START, return to IDLE, no frame_done, a_ack pulsed once only.
REQ-039 Spurious start: gp_frame_start pulsed during STREAM cycle 10 -> stream length stays 64 cycles.
REQ-040 Reset at STREAM cycle 30 -> all outputs 0 immediately; a subsequent b_req is served with normal REQ-024 latency.

Source files
------------

// File: rtl/raster_cmd_scheduler_if.sv
// Raster command scheduler bus: two requesters plus the graphics processor
// command/frame handshake, bundled for the scheduler and its environment.
interface raster_cmd_scheduler_if;
   logic        a_req;
   logic [1:0]  a_cmd;
   logic [17:0] a_args;
   logic        a_ack;
   logic        b_req;
   logic [1:0]  b_cmd;
   logic [17:0] b_args;
   logic        b_ack;
   logic [1:0]  gp_command;
   logic [17:0] gp_args;
   logic        gp_command_valid;
   logic        gp_frame_start;
   logic        frame_active;
   logic        frame_owner;
   logic        frame_done;
   logic        err_timeout;
   logic        busy;

   modport master (
      output a_req, a_cmd, a_args, b_req, b_cmd, b_args, gp_frame_start,
      input  a_ack, b_ack, gp_command, gp_args, gp_command_valid,
      input  frame_active, frame_owner, frame_done, err_timeout, busy
   );

   modport slave (
      input  a_req, a_cmd, a_args, b_req, b_cmd, b_args, gp_frame_start,
      output a_ack, b_ack, gp_command, gp_args, gp_command_valid,
      output frame_active, frame_owner, frame_done, err_timeout, busy
   );
endinterface

// File: rtl/raster_cmd_scheduler.sv
// Round-robin scheduler granting one of two requesters a graphics processor
// frame: issue, wait for frame start (with timeout), stream, guard cycle.
module raster_cmd_scheduler #(
   parameter int FRAME_PIXELS  = 64,
   parameter int START_TIMEOUT = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   raster_cmd_scheduler_if.slave bus
);
   localparam int CMAX = (FRAME_PIXELS > START_TIMEOUT) ? FRAME_PIXELS : START_TIMEOUT;
   localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, STREAM, GUARD} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    cmd, cmd_n;
   logic [17:0]   args, args_n;
   logic          owner, owner_n;
   logic          prio_b, prio_b_n;
   logic          valid, valid_n;
   logic          ack_a, ack_a_n;
   logic          ack_b, ack_b_n;
   logic          active, active_n;
   logic          done, done_n;
   logic          tout, tout_n;
   logic          busy, busy_n;
   logic          grant_b;

   // Next-state and next-output logic; every output is a register fed from here
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      cmd_n    = cmd;
      args_n   = args;
      owner_n  = owner;
      prio_b_n = prio_b;
      valid_n  = 1'b0;
      ack_a_n  = 1'b0;
      ack_b_n  = 1'b0;
      active_n = 1'b0;
      done_n   = 1'b0;
      tout_n   = 1'b0;
      grant_b  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               grant_b  = bus.b_req && (!bus.a_req || prio_b);
               state_n  = ISSUE;
               owner_n  = grant_b;
               cmd_n    = grant_b ? bus.b_cmd : bus.a_cmd;
               args_n   = grant_b ? bus.b_args : bus.a_args;
               prio_b_n = !grant_b;
               valid_n  = 1'b1;
               ack_a_n  = !grant_b;
               ack_b_n  = grant_b;
            end
         end
         ISSUE: begin
            state_n = WAIT_START;
            cnt_n   = '0;
         end
         WAIT_START: begin
            if (bus.gp_frame_start) begin
               state_n  = STREAM;
               cnt_n    = '0;
               active_n = 1'b1;
            end else if (cnt == CW'(START_TIMEOUT - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
               tout_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STREAM: begin
            if (cnt == CW'(FRAME_PIXELS - 1)) begin
               state_n = GUARD;
               cnt_n   = '0;
               done_n  = 1'b1;
            end else begin
               cnt_n    = cnt + 1'b1;
               active_n = 1'b1;
            end
         end
         GUARD: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // State, counter, arbitration pointer and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         cmd    <= '0;
         args   <= '0;
         owner  <= 1'b0;
         prio_b <= 1'b0;
         valid  <= 1'b0;
         ack_a  <= 1'b0;
         ack_b  <= 1'b0;
         active <= 1'b0;
         done   <= 1'b0;
         tout   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         cmd    <= cmd_n;
         args   <= args_n;
         owner  <= owner_n;
         prio_b <= prio_b_n;
         valid  <= valid_n;
         ack_a  <= ack_a_n;
         ack_b  <= ack_b_n;
         active <= active_n;
         done   <= done_n;
         tout   <= tout_n;
         busy   <= busy_n;
      end
   end

   assign bus.gp_command       = cmd;
   assign bus.gp_args          = args;
   assign bus.gp_command_valid = valid;
   assign bus.a_ack            = ack_a;
   assign bus.b_ack            = ack_b;
   assign bus.frame_active     = active;
   assign bus.frame_owner      = owner;
   assign bus.frame_done       = done;
   assign bus.err_timeout      = tout;
   assign bus.busy             = busy;
endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Self-checking bench for raster_cmd_scheduler: arbitration vector table
// plus hand-written frame, contention, timeout and reset sequences.
module tb_raster_cmd_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_active = 0;
   int   n_done = 0;
   int   n_tout = 0;
   int   n_aack = 0;
   int   n_back = 0;
   int   n_bad = 0;
   logic prev_active = 1'b0;
   bit   proc_en = 1'b0;
   int   spur_at = -1;

   typedef struct {
      logic        a_req;
      logic        b_req;
      logic [1:0]  a_cmd;
      logic [17:0] a_args;
      logic [1:0]  b_cmd;
      logic [17:0] b_args;
      logic        valid;
      logic        a_ack;
      logic        b_ack;
      logic        owner;
      logic [1:0]  cmd;
      logic [17:0] args;
   } vec_t;

   raster_cmd_scheduler_if bus();

   raster_cmd_scheduler #(
      .FRAME_PIXELS (64),
      .START_TIMEOUT(7)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] pk(input int x1, input int y1, input int x2,
                                      input int y2, input int w, input int h);
      return {x1[2:0], y1[2:0], x2[2:0], y2[2:0], w[2:0], h[2:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({bus.gp_command, bus.gp_args, bus.gp_command_valid, bus.a_ack,
                  bus.b_ack, bus.frame_active, bus.frame_owner, bus.frame_done,
                  bus.err_timeout, bus.busy});
   endfunction

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Event counters sampled 1 time unit after each rising edge
   always @(posedge clk) begin
      #1;
      if (bus.frame_active) n_active++;
      if (bus.frame_done) begin
         n_done++;
         if (bus.frame_active || !prev_active) n_bad++;
      end
      if (bus.err_timeout) n_tout++;
      if (bus.a_ack) n_aack++;
      if (bus.b_ack) n_back++;
      prev_active = bus.frame_active;
   end

   // Processor model: frame_start two cycles after the issue strobe,
   // optional stray frame_start spur_at cycles into the stream
   initial begin
      bus.gp_frame_start = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (proc_en && bus.gp_command_valid) begin
            @(negedge clk);
            @(negedge clk);
            bus.gp_frame_start = 1'b1;
            @(negedge clk);
            bus.gp_frame_start = 1'b0;
            if (spur_at >= 0) begin
               repeat (spur_at) @(negedge clk);
               bus.gp_frame_start = 1'b1;
               @(negedge clk);
               bus.gp_frame_start = 1'b0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      int   s_act, s_done, s_tout, s_a, s_b, s_bad;
      int   found;
      bit   got;

      tbl[0] = '{1'b1, 1'b1, 2'd1, pk(3,5,0,0,0,0), 2'd2, pk(1,2,3,4,5,6),
                 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, pk(3,5,0,0,0,0)};
      tbl[1] = '{1'b1, 1'b1, 2'd3, pk(7,7,7,7,7,7), 2'd0, pk(6,5,4,3,2,1),
                 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, pk(6,5,4,3,2,1)};
      tbl[2] = '{1'b0, 1'b1, 2'd2, pk(1,1,1,1,1,1), 2'd3, pk(0,1,0,1,0,1),
                 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, pk(0,1,0,1,0,1)};
      tbl[3] = '{1'b1, 1'b1, 2'd2, pk(4,0,4,0,4,0), 2'd1, pk(2,2,2,2,2,2),
                 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, pk(4,0,4,0,4,0)};
      tbl[4] = '{1'b1, 1'b0, 2'd1, pk(0,0,0,0,0,7), 2'd2, pk(7,0,0,0,0,0),
                 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, pk(0,0,0,0,0,7)};
      tbl[5] = '{1'b1, 1'b1, 2'd0, pk(1,3,5,7,1,3), 2'd2, pk(7,0,0,0,0,0),
                 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, pk(7,0,0,0,0,0)};
      tbl[6] = '{1'b0, 1'b0, 2'd3, pk(7,7,7,7,7,7), 2'd3, pk(7,7,7,7,7,7),
                 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, pk(7,0,0,0,0,0)};
      tbl[7] = '{1'b1, 1'b0, 2'd3, pk(5,5,5,5,5,5), 2'd0, pk(0,0,0,0,0,0),
                 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, pk(5,5,5,5,5,5)};

      bus.a_req  = 1'b1;
      bus.b_req  = 1'b1;
      bus.a_cmd  = 2'd3;
      bus.a_args = pk(7,7,7,7,7,7);
      bus.b_cmd  = 2'd3;
      bus.b_args = pk(7,7,7,7,7,7);
      rst = 1'b1;

      // reset state with requests asserted
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), 32'd0);
      @(negedge clk);
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      rst = 1'b0;

      // arbitration table, processor silent so each grant ends in timeout
      proc_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.a_req  = tbl[i].a_req;
         bus.b_req  = tbl[i].b_req;
         bus.a_cmd  = tbl[i].a_cmd;
         bus.a_args = tbl[i].a_args;
         bus.b_cmd  = tbl[i].b_cmd;
         bus.b_args = tbl[i].b_args;
         @(posedge clk); #1;
         chk($sformatf("v%0d_valid", i), 32'(bus.gp_command_valid), 32'(tbl[i].valid));
         chk($sformatf("v%0d_a_ack", i), 32'(bus.a_ack), 32'(tbl[i].a_ack));
         chk($sformatf("v%0d_b_ack", i), 32'(bus.b_ack), 32'(tbl[i].b_ack));
         chk($sformatf("v%0d_owner", i), 32'(bus.frame_owner), 32'(tbl[i].owner));
         chk($sformatf("v%0d_cmd", i), 32'(bus.gp_command), 32'(tbl[i].cmd));
         chk($sformatf("v%0d_args", i), 32'(bus.gp_args), 32'(tbl[i].args));
         chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].valid));
         @(negedge clk);
         bus.a_req = 1'b0;
         bus.b_req = 1'b0;
         if (tbl[i].valid) wait_idle($sformatf("v%0d_idle", i));
      end

      // single request with a full 64-pixel frame
      do_reset();
      proc_en = 1'b1;
      spur_at = -1;
      s_act = n_active; s_done = n_done; s_tout = n_tout; s_a = n_aack; s_bad = n_bad;
      bus.a_req  = 1'b1;
      bus.a_cmd  = 2'd1;
      bus.a_args = pk(3,5,0,0,0,0);
      @(posedge clk); #1;
      chk("single_valid", 32'(bus.gp_command_valid), 32'd1);
      chk("single_ack", 32'(bus.a_ack), 32'd1);
      chk("single_cmd", 32'(bus.gp_command), 32'd1);
      chk("single_args", 32'(bus.gp_args), 32'(pk(3,5,0,0,0,0)));
      @(negedge clk);
      bus.a_req = 1'b0;
      @(posedge clk); #1;
      chk("single_valid_once", 32'(bus.gp_command_valid), 32'd0);
      chk("single_ack_once", 32'(bus.a_ack), 32'd0);
      wait_idle("single_idle");
      @(negedge clk);
      chk("single_active_len", 32'(n_active - s_act), 32'd64);
      chk("single_done_cnt", 32'(n_done - s_done), 32'd1);
      chk("single_done_align", 32'(n_bad - s_bad), 32'd0);
      chk("single_no_tout", 32'(n_tout - s_tout), 32'd0);
      chk("single_ack_cnt", 32'(n_aack - s_a), 32'd1);
      chk("single_args_hold", 32'(bus.gp_args), 32'(pk(3,5,0,0,0,0)));

      // stray frame_start during stream cycle 10
      spur_at = 10;
      s_act = n_active; s_done = n_done;
      bus.a_req = 1'b1;
      @(posedge clk); #1;
      chk("spur_valid", 32'(bus.gp_command_valid), 32'd1);
      @(negedge clk);
      bus.a_req = 1'b0;
      wait_idle("spur_idle");
      @(negedge clk);
      chk("spur_active_len", 32'(n_active - s_act), 32'd64);
      chk("spur_done_cnt", 32'(n_done - s_done), 32'd1);
      spur_at = -1;

      // contention: both requests held from reset
      @(negedge clk);
      rst = 1'b1;
      bus.a_req = 1'b1;
      bus.b_req = 1'b1;
      bus.a_cmd = 2'd1;
      bus.b_cmd = 2'd2;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      s_a = n_aack; s_b = n_back; s_done = n_done;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (bus.gp_command_valid) begin
               got = 1'b1;
               break;
            end
         end
         chk($sformatf("rr%0d_grant", k), 32'(got), 32'd1);
         chk($sformatf("rr%0d_owner", k), 32'(bus.frame_owner), 32'(k % 2));
         chk($sformatf("rr%0d_a_ack", k), 32'(bus.a_ack), 32'((k + 1) % 2));
         chk($sformatf("rr%0d_b_ack", k), 32'(bus.b_ack), 32'(k % 2));
         chk($sformatf("rr%0d_cmd", k), 32'(bus.gp_command), 32'((k % 2) + 1));
      end
      @(negedge clk);
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      wait_idle("rr_idle");
      @(negedge clk);
      chk("rr_a_ack_cnt", 32'(n_aack - s_a), 32'd2);
      chk("rr_b_ack_cnt", 32'(n_back - s_b), 32'd2);
      chk("rr_done_cnt", 32'(n_done - s_done), 32'd4);

      // start timeout with the processor silent
      do_reset();
      proc_en = 1'b0;
      s_a = n_aack; s_done = n_done; s_tout = n_tout;
      bus.a_req = 1'b1;
      @(posedge clk); #1;
      chk("tout_valid", 32'(bus.gp_command_valid), 32'd1);
      @(negedge clk);
      bus.a_req = 1'b0;
      found = -1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (bus.err_timeout) begin
            found = c;
            break;
         end
      end
      chk("tout_delay", 32'(found), 32'd7);
      chk("tout_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      chk("tout_pulse_once", 32'(bus.err_timeout), 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("tout_cnt", 32'(n_tout - s_tout), 32'd1);
      chk("tout_no_done", 32'(n_done - s_done), 32'd0);
      chk("tout_ack_cnt", 32'(n_aack - s_a), 32'd1);

      // request raised and dropped between edges is never seen
      @(posedge clk); #1;
      bus.a_req = 1'b1;
      @(negedge clk);
      bus.a_req = 1'b0;
      @(posedge clk); #1;
      chk("drop_valid", 32'(bus.gp_command_valid), 32'd0);
      chk("drop_ack", 32'(bus.a_ack), 32'd0);

      // reset at stream cycle 30, then a B request after reset
      proc_en = 1'b1;
      @(negedge clk);
      bus.a_req = 1'b1;
      bus.a_cmd = 2'd2;
      @(posedge clk); #1;
      @(negedge clk);
      bus.a_req = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (bus.frame_active) begin
            got = 1'b1;
            break;
         end
      end
      chk("mid_stream_start", 32'(got), 32'd1);
      repeat (30) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_reset_outputs", outs(), 32'd0);
      s_done = n_done; s_tout = n_tout; s_b = n_back;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid_no_done", 32'(n_done - s_done), 32'd0);
      chk("mid_no_tout", 32'(n_tout - s_tout), 32'd0);
      chk("mid_idle_outputs", outs(), 32'd0);
      bus.b_req  = 1'b1;
      bus.b_cmd  = 2'd3;
      bus.b_args = pk(2,4,6,1,3,5);
      @(posedge clk); #1;
      chk("post_b_valid", 32'(bus.gp_command_valid), 32'd1);
      chk("post_b_ack", 32'(bus.b_ack), 32'd1);
      chk("post_b_owner", 32'(bus.frame_owner), 32'd1);
      chk("post_b_args", 32'(bus.gp_args), 32'(pk(2,4,6,1,3,5)));
      @(negedge clk);
      bus.b_req = 1'b0;
      wait_idle("post_b_idle");
      @(negedge clk);
      chk("post_b_done", 32'(n_done - s_done), 32'd1);
      chk("post_b_ack_cnt", 32'(n_back - s_b), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
